// File: rtl/store_buffer_ctrl_if.sv
// Store buffer controller: shared package and port interface.
// store_buffer_ctrl_pkg  - default entry count.
// store_buffer_ctrl_if   - groups the allocate, write-back, commit, flush,
//                          drain and status signals of store_buffer_ctrl.
//    slave  : controller side (store_buffer_ctrl)
//    master : pipeline / data-cache side (driver)
package store_buffer_ctrl_pkg;
   localparam int unsigned SB_ENTRY_DEF = 8;
endpackage

interface store_buffer_ctrl_if #(
   parameter int unsigned SB_ENTRY = store_buffer_ctrl_pkg::SB_ENTRY_DEF,
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DATA_W   = 16
);
   localparam int unsigned IW = $clog2(SB_ENTRY);

   logic                alloc_v_i;
   logic                alloc_ready_o;
   logic [IW-1:0]       alloc_sb_num_o;
   logic                wb_v_i;
   logic [IW-1:0]       wb_sb_num_i;
   logic [ADDR_W-1:0]   wb_addr_i;
   logic [DATA_W-1:0]   wb_data_i;
   logic                commit_v_i;
   logic                commit_ready_o;
   logic                flush_i;
   logic                mem_v_o;
   logic [ADDR_W-1:0]   mem_addr_o;
   logic [DATA_W-1:0]   mem_data_o;
   logic                mem_ready_i;
   logic [SB_ENTRY-1:0] sb_wb_vector_o;
   logic [IW-1:0]       sb_commit_pt_o;
   logic                sb_empty_o;

   modport slave (
      input  alloc_v_i, wb_v_i, wb_sb_num_i, wb_addr_i, wb_data_i,
             commit_v_i, flush_i, mem_ready_i,
      output alloc_ready_o, alloc_sb_num_o, commit_ready_o, mem_v_o,
             mem_addr_o, mem_data_o, sb_wb_vector_o, sb_commit_pt_o, sb_empty_o
   );

   modport master (
      output alloc_v_i, wb_v_i, wb_sb_num_i, wb_addr_i, wb_data_i,
             commit_v_i, flush_i, mem_ready_i,
      input  alloc_ready_o, alloc_sb_num_o, commit_ready_o, mem_v_o,
             mem_addr_o, mem_data_o, sb_wb_vector_o, sb_commit_pt_o, sb_empty_o
   );
endinterface

// File: rtl/store_buffer_ctrl.sv
// Circular store buffer controller with head / commit / tail pointers and a
// two-state drain FSM feeding the data cache.
// Ports:
//    clk_i      - clock, all state changes on rising edge
//    reset_n_i  - asynchronous active-low reset
//    sb_if      - store_buffer_ctrl_if.slave: allocate, write-back, commit,
//                 flush, drain request/accept, per-entry wb flags, status
module store_buffer_ctrl #(
   parameter int unsigned SB_ENTRY = store_buffer_ctrl_pkg::SB_ENTRY_DEF,
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DATA_W   = 16
) (
   input logic                clk_i,
   input logic                reset_n_i,
   store_buffer_ctrl_if.slave sb_if
);
   localparam int unsigned IW = $clog2(SB_ENTRY);
   localparam int unsigned CW = IW + 1;
   localparam logic [CW-1:0] FULL = CW'(SB_ENTRY);

   localparam logic [0:0] D_IDLE = 1'b0;
   localparam logic [0:0] D_REQ  = 1'b1;

   logic [IW-1:0]       head_q, head_d;
   logic [IW-1:0]       cpt_q, cpt_d;
   logic [IW-1:0]       tail_q, tail_d;
   logic [CW-1:0]       count_q, count_d;
   // committed-but-undrained entries; disambiguates head == commit_pt when full
   logic [CW-1:0]       cmt_q, cmt_d;
   logic [SB_ENTRY-1:0] wb_q, wb_d;
   logic [0:0]          state_q, state_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_data_q, mem_data_d;

   logic [ADDR_W-1:0]   addr_mem [SB_ENTRY];
   logic [DATA_W-1:0]   data_mem [SB_ENTRY];

   logic                alloc_ready, commit_ready;
   logic                alloc_fire, commit_fire, wb_fire, free;
   logic [IW-1:0]       wb_off, off, load_idx;
   logic [CW-1:0]       cmt_c;
   logic                load;

   always_comb begin
      alloc_ready  = (count_q != FULL);
      commit_ready = ((count_q - cmt_q) != '0) && wb_q[cpt_q];
      commit_fire  = sb_if.commit_v_i && commit_ready;
      alloc_fire   = sb_if.alloc_v_i && alloc_ready && !sb_if.flush_i;
      wb_off       = sb_if.wb_sb_num_i - head_q;
      wb_fire      = sb_if.wb_v_i && ({1'b0, wb_off} < count_q);
      free         = (state_q == D_REQ) && sb_if.mem_ready_i;
      cmt_c        = cmt_q + CW'(commit_fire);

      // drain FSM; the next entry is chosen from registered state only
      state_d  = state_q;
      load     = 1'b0;
      load_idx = head_q;
      case (state_q)
         D_IDLE: begin
            if (cmt_q != '0) begin
               state_d = D_REQ;
               load    = 1'b1;
            end
         end
         default: begin
            if (sb_if.mem_ready_i) begin
               if (cmt_q > CW'(1)) begin
                  load     = 1'b1;
                  load_idx = head_q + IW'(1);
               end else begin
                  state_d = D_IDLE;
               end
            end
         end
      endcase
      mem_addr_d = load ? addr_mem[load_idx] : mem_addr_q;
      mem_data_d = load ? data_mem[load_idx] : mem_data_q;

      cpt_d  = cpt_q + IW'(commit_fire);
      head_d = head_q + IW'(free);
      cmt_d  = cmt_c - CW'(free);
      if (sb_if.flush_i) begin
         tail_d  = cpt_d;
         count_d = cmt_d;
      end else begin
         tail_d  = tail_q + IW'(alloc_fire);
         count_d = count_q + CW'(alloc_fire) - CW'(free);
      end

      // set first so a same-cycle free or flush wins over the write-back
      wb_d = wb_q;
      if (wb_fire)    wb_d[sb_if.wb_sb_num_i] = 1'b1;
      if (free)       wb_d[head_q] = 1'b0;
      if (alloc_fire) wb_d[tail_q] = 1'b0;
      off = '0;
      for (int unsigned i = 0; i < SB_ENTRY; i++) begin
         off = IW'(i) - head_q;
         if (sb_if.flush_i && ({1'b0, off} >= cmt_c)) wb_d[i] = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         head_q  <= '0;
         cpt_q   <= '0;
         tail_q  <= '0;
         count_q <= '0;
         cmt_q   <= '0;
         wb_q    <= '0;
         state_q <= D_IDLE;
      end else begin
         head_q  <= head_d;
         cpt_q   <= cpt_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         cmt_q   <= cmt_d;
         wb_q    <= wb_d;
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wb_fire) begin
         addr_mem[sb_if.wb_sb_num_i] <= sb_if.wb_addr_i;
         data_mem[sb_if.wb_sb_num_i] <= sb_if.wb_data_i;
      end
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
   end

   assign sb_if.alloc_ready_o  = alloc_ready;
   assign sb_if.alloc_sb_num_o = tail_q;
   assign sb_if.commit_ready_o = commit_ready;
   assign sb_if.mem_v_o        = (state_q == D_REQ);
   assign sb_if.mem_addr_o     = mem_addr_q;
   assign sb_if.mem_data_o     = mem_data_q;
   assign sb_if.sb_wb_vector_o = wb_q;
   assign sb_if.sb_commit_pt_o = cpt_q;
   assign sb_if.sb_empty_o     = (count_q == '0);
endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Self-checking bench for store_buffer_ctrl (SB_ENTRY=8, 16-bit addr/data).
module tb_store_buffer_ctrl;
   localparam int SB = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   store_buffer_ctrl_if #(.SB_ENTRY(SB), .ADDR_W(16), .DATA_W(16)) sbi ();
   store_buffer_ctrl #(.SB_ENTRY(SB), .ADDR_W(16), .DATA_W(16)) dut (
      .clk_i(clk), .reset_n_i(rst_n), .sb_if(sbi)
   );

   int total = 0;
   int bad = 0;

   // reference model: queue of allocated entries, oldest first
   typedef struct packed { logic [15:0] a; logic [15:0] d; logic wb; } ent_t;
   ent_t q[$];
   int head_m, ncom;
   logic mv_m;
   logic [15:0] ma_m, md_m;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic m_cr();
      if (ncom < q.size()) return q[ncom].wb;
      return 1'b0;
   endfunction

   function automatic logic [7:0] m_wbvec();
      logic [7:0] v = '0;
      for (int k = 0; k < q.size(); k++) if (q[k].wb) v[(head_m + k) % SB] = 1'b1;
      return v;
   endfunction

   task automatic m_reset();
      q.delete(); head_m = 0; ncom = 0; mv_m = 1'b0; ma_m = '0; md_m = '0;
   endtask

   task automatic m_step(input logic al, input logic wv, input logic [2:0] wn,
                         input logic [15:0] wa, input logic [15:0] wd,
                         input logic cm, input logic fl, input logic rdy);
      int sz = q.size();
      int k;
      logic cfire = cm && m_cr();
      logic afire = al && (sz < SB) && !fl;
      logic fr = mv_m && rdy;
      ent_t e;
      if (mv_m) begin
         if (rdy) begin
            if (ncom > 1) begin ma_m = q[1].a; md_m = q[1].d; end
            else mv_m = 1'b0;
         end
      end else if (ncom > 0) begin
         mv_m = 1'b1; ma_m = q[0].a; md_m = q[0].d;
      end
      if (wv) begin
         k = (int'(wn) - head_m + SB) % SB;
         if (k < sz) begin e = q[k]; e.wb = 1'b1; e.a = wa; e.d = wd; q[k] = e; end
      end
      ncom = ncom + int'(cfire);
      if (fl) while (q.size() > ncom) void'(q.pop_back());
      if (afire) q.push_back('0);
      if (fr) begin void'(q.pop_front()); head_m = (head_m + 1) % SB; ncom--; end
   endtask

   task automatic drive(input logic al, input logic wv, input logic [2:0] wn,
                        input logic [15:0] wa, input logic [15:0] wd,
                        input logic cm, input logic fl, input logic rdy);
      sbi.alloc_v_i = al; sbi.wb_v_i = wv; sbi.wb_sb_num_i = wn;
      sbi.wb_addr_i = wa; sbi.wb_data_i = wd; sbi.commit_v_i = cm;
      sbi.flush_i = fl; sbi.mem_ready_i = rdy;
   endtask

   // one clock: inputs applied at negedge, outputs observed at the next negedge
   task automatic cyc(input logic al, input logic wv, input logic [2:0] wn,
                      input logic [15:0] wa, input logic [15:0] wd,
                      input logic cm, input logic fl, input logic rdy);
      drive(al, wv, wn, wa, wd, cm, fl, rdy);
      @(posedge clk);
      m_step(al, wv, wn, wa, wd, cm, fl, rdy);
      @(negedge clk);
   endtask

   task automatic idle(input logic rdy);
      cyc(0, 0, 0, 0, 0, 0, 0, rdy);
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_reset();
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".alloc_ready"}, sbi.alloc_ready_o, q.size() < SB);
      chk({tag, ".alloc_num"}, sbi.alloc_sb_num_o, (head_m + q.size()) % SB);
      chk({tag, ".commit_ready"}, sbi.commit_ready_o, m_cr());
      chk({tag, ".commit_pt"}, sbi.sb_commit_pt_o, (head_m + ncom) % SB);
      chk({tag, ".empty"}, sbi.sb_empty_o, q.size() == 0);
      chk({tag, ".wbvec"}, sbi.sb_wb_vector_o, m_wbvec());
      chk({tag, ".mem_v"}, sbi.mem_v_o, mv_m);
      if (mv_m) begin
         chk({tag, ".mem_addr"}, sbi.mem_addr_o, ma_m);
         chk({tag, ".mem_data"}, sbi.mem_data_o, md_m);
      end
   endtask

   typedef struct {
      logic al, wv; logic [2:0] wn; logic [15:0] wa, wd; logic cm, fl, rdy;
      logic e_ar; logic [2:0] e_num; logic e_cr; logic [2:0] e_cpt; logic e_emp;
      logic [7:0] e_wbv; logic e_mv; logic [15:0] e_ma, e_md;
   } vec_t;
   vec_t tbl[8];

   initial begin
      // basic drain: alloc 0..2, write back, commit, drain in order
      tbl[0] = '{1,0,0,16'h000,16'h00,0,0,1, 1,1,0,0,0,8'h00,0,16'h000,16'h00};
      tbl[1] = '{1,1,0,16'h100,16'hA0,0,0,1, 1,2,1,0,0,8'h01,0,16'h000,16'h00};
      tbl[2] = '{1,1,1,16'h101,16'hA1,0,0,1, 1,3,1,0,0,8'h03,0,16'h000,16'h00};
      tbl[3] = '{0,1,2,16'h102,16'hA2,1,0,1, 1,3,1,1,0,8'h07,0,16'h000,16'h00};
      tbl[4] = '{0,0,0,16'h000,16'h00,1,0,1, 1,3,1,2,0,8'h07,1,16'h100,16'hA0};
      tbl[5] = '{0,0,0,16'h000,16'h00,1,0,1, 1,3,0,3,0,8'h06,1,16'h101,16'hA1};
      tbl[6] = '{0,0,0,16'h000,16'h00,0,0,1, 1,3,0,3,0,8'h04,1,16'h102,16'hA2};
      tbl[7] = '{0,0,0,16'h000,16'h00,0,0,1, 1,3,0,3,1,8'h00,0,16'h000,16'h00};

      do_reset();
      chk("rst.alloc_ready", sbi.alloc_ready_o, 1);
      chk("rst.empty", sbi.sb_empty_o, 1);
      chk("rst.commit_ready", sbi.commit_ready_o, 0);
      chk("rst.mem_v", sbi.mem_v_o, 0);
      for (int i = 0; i < 8; i++) begin
         cyc(tbl[i].al, tbl[i].wv, tbl[i].wn, tbl[i].wa, tbl[i].wd, tbl[i].cm, tbl[i].fl, tbl[i].rdy);
         chk($sformatf("v%0d.alloc_ready", i), sbi.alloc_ready_o, tbl[i].e_ar);
         chk($sformatf("v%0d.alloc_num", i), sbi.alloc_sb_num_o, tbl[i].e_num);
         chk($sformatf("v%0d.commit_ready", i), sbi.commit_ready_o, tbl[i].e_cr);
         chk($sformatf("v%0d.commit_pt", i), sbi.sb_commit_pt_o, tbl[i].e_cpt);
         chk($sformatf("v%0d.empty", i), sbi.sb_empty_o, tbl[i].e_emp);
         chk($sformatf("v%0d.wbvec", i), sbi.sb_wb_vector_o, tbl[i].e_wbv);
         chk($sformatf("v%0d.mem_v", i), sbi.mem_v_o, tbl[i].e_mv);
         if (tbl[i].e_mv) begin
            chk($sformatf("v%0d.mem_addr", i), sbi.mem_addr_o, tbl[i].e_ma);
            chk($sformatf("v%0d.mem_data", i), sbi.mem_data_o, tbl[i].e_md);
         end
      end

      // commit gating
      do_reset();
      cyc(1, 0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1, 0, 1);
      chk("gate.cpt_nowb", sbi.sb_commit_pt_o, 0);
      chk("gate.cr_nowb", sbi.commit_ready_o, 0);
      cyc(0, 1, 0, 16'h200, 16'h300, 0, 0, 1);
      chk("gate.cr_wb", sbi.commit_ready_o, 1);
      cyc(0, 0, 0, 0, 0, 1, 0, 1);
      chk("gate.cpt_commit", sbi.sb_commit_pt_o, 1);

      // backpressure
      do_reset();
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 16'h0BEE, 16'h0CAF, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      chk("bp.latency", sbi.mem_v_o, 0);
      for (int i = 0; i < 5; i++) begin
         idle(0);
         chk($sformatf("bp%0d.mem_v", i), sbi.mem_v_o, 1);
         chk($sformatf("bp%0d.mem_addr", i), sbi.mem_addr_o, 16'h0BEE);
         chk($sformatf("bp%0d.mem_data", i), sbi.mem_data_o, 16'h0CAF);
         chk($sformatf("bp%0d.wbvec", i), sbi.sb_wb_vector_o, 8'h01);
      end
      idle(1);
      chk("bp.done_mem_v", sbi.mem_v_o, 0);
      chk("bp.done_empty", sbi.sb_empty_o, 1);

      // full and wrap
      do_reset();
      for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("full.alloc_ready", sbi.alloc_ready_o, 0);
      chk("full.alloc_num", sbi.alloc_sb_num_o, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("full.alloc_dropped", sbi.alloc_ready_o, 0);
      for (int i = 0; i < 8; i++) cyc(0, 1, 3'(i), 16'h300 + 16'(i), 16'h400 + 16'(i), 0, 0, 0);
      chk("full.cr_all_uncommitted", sbi.commit_ready_o, 1);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      chk("full.cpt", sbi.sb_commit_pt_o, 2);
      chk("full.mem_addr0", sbi.mem_addr_o, 16'h300);
      idle(1);
      chk("full.mem_addr1", sbi.mem_addr_o, 16'h301);
      idle(1);
      chk("wrap.alloc_ready", sbi.alloc_ready_o, 1);
      chk("wrap.alloc_num0", sbi.alloc_sb_num_o, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("wrap.alloc_num1", sbi.alloc_sb_num_o, 1);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("wrap.full_again", sbi.alloc_ready_o, 0);
      chk("wrap.alloc_num2", sbi.alloc_sb_num_o, 2);

      // flush with same-cycle alloc
      do_reset();
      for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 1, 3'(i), 16'h500 + 16'(i), 16'h600 + 16'(i), 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 1, 0);
      chk("flush.tail", sbi.alloc_sb_num_o, 2);
      chk("flush.wbvec", sbi.sb_wb_vector_o, 8'h03);
      chk("flush.cpt", sbi.sb_commit_pt_o, 2);
      chk("flush.cr", sbi.commit_ready_o, 0);
      for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("flush.count_full", sbi.alloc_ready_o, 0);
      chk("flush.tail_wrap", sbi.alloc_sb_num_o, 0);

      // asynchronous reset mid-drain
      chk("rmd.mem_v_before", sbi.mem_v_o, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rmd.mem_v", sbi.mem_v_o, 0);
      chk("rmd.alloc_ready", sbi.alloc_ready_o, 1);
      chk("rmd.empty", sbi.sb_empty_o, 1);
      chk("rmd.commit_ready", sbi.commit_ready_o, 0);
      chk("rmd.alloc_num", sbi.alloc_sb_num_o, 0);
      chk("rmd.cpt", sbi.sb_commit_pt_o, 0);
      chk("rmd.wbvec", sbi.sb_wb_vector_o, 0);
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // randomized against the reference model
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         cyc(($urandom_range(0, 9) < 6), ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)),
             16'($urandom), 16'($urandom), ($urandom_range(0, 1) == 1),
             ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7));
         check_all($sformatf("rnd%0d", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/store_buffer_ctrl.md
STORE_BUFFER_CTRL -- requirements
Module: store_buffer_ctrl

Interface
REQ-001 SHALL take parameter SB_ENTRY, default from package (8), the number of store buffer entries; it SHALL be a power of two, at least 2.
REQ-002 SHALL take parameter ADDR_W, default 16, the store address width.
REQ-003 SHALL take parameter DATA_W, default 16, the store data width.
REQ-004 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-005 reset_n_i  in  1  asynchronous, active-low reset.
REQ-006 alloc_v_i  in  1  dispatch requests one store buffer entry.
REQ-007 alloc_ready_o  out  1  an entry can be allocated this cycle.
REQ-008 alloc_sb_num_o  out  $clog2(SB_ENTRY)  entry number granted (current tail).
REQ-009 wb_v_i / wb_sb_num_i / wb_addr_i / wb_data_i  in  1 / $clog2(SB_ENTRY) / ADDR_W / DATA_W  store address and data written back for an entry.
REQ-010 commit_v_i  in  1  the ROB retires the oldest uncommitted store.
REQ-011 commit_ready_o  out  1  the entry at the commit pointer is allocated and written back.
REQ-012 flush_i  in  1  pipeline flush; discards every uncommitted entry.
REQ-013 mem_v_o / mem_addr_o / mem_data_o  out  1 / ADDR_W / DATA_W  drain request to the data cache.
REQ-014 mem_ready_i  in  1  the data cache accepts the drain request.
REQ-015 sb_wb_vector_o  out  SB_ENTRY  per-entry written-back flag, for the previous-store check.
REQ-016 sb_commit_pt_o  out  $clog2(SB_ENTRY)  index of the oldest uncommitted entry.
REQ-017 sb_empty_o  out  1  no entry is allocated.

Function
REQ-018 The buffer SHALL be circular, with three pointers: head (oldest undrained entry), commit_pt (oldest uncommitted entry) and tail (next entry to allocate).
- Ordering: head <= commit_pt <= tail, modulo SB_ENTRY.
- Each pointer wraps from SB_ENTRY-1 to 0.
REQ-019 The block SHALL keep count, width $clog2(SB_ENTRY)+1, of allocated entries.
- alloc_ready_o = (count != SB_ENTRY).
- sb_empty_o = (count == 0).
REQ-020 Allocation SHALL occur on alloc_v_i && alloc_ready_o && !flush_i.
- alloc_sb_num_o equals the tail value before the edge.
- On the edge, tail increments and the entry's wb bit clears.
REQ-021 On wb_v_i, the block SHALL set sb_wb_vector_o[wb_sb_num_i] and latch the address and data on the next edge.
- A wb to an unallocated entry SHALL be ignored.
REQ-022 commit_ready_o = (commit_pt != tail || count == SB_ENTRY with all entries uncommitted) && sb_wb_vector_o[commit_pt].
- A commit_v_i while commit_ready_o is low SHALL be ignored.
- A commit_v_i while commit_ready_o is high advances commit_pt by 1.
REQ-023 Drain FSM SHALL have two states, D_IDLE and D_REQ.
- D_IDLE -> D_REQ when head != commit_pt, i.e. a committed entry exists; the head entry's address and data are loaded into mem_addr_o and mem_data_o.
- In D_REQ: mem_v_o = 1, and address and data stay stable until mem_ready_i.
- On mem_v_o && mem_ready_i: the head entry is freed (wb bit cleared, head+1, count-1), then go to D_REQ again if another committed entry remains, else D_IDLE.
- No bubble cycle between back-to-back drains.
REQ-024 Drain latency SHALL be 1 cycle: mem_v_o asserts on the edge after the commit that makes head != commit_pt.
REQ-025 When alloc and free occur in the same cycle, count SHALL be unchanged. Allocation into a full buffer is impossible even if a free occurs that cycle; no bypass.
REQ-026 flush_i SHALL discard all uncommitted entries on the next edge.
- tail <- commit_pt (after any same-cycle commit); count <- entries from head to commit_pt.
- wb bits of the discarded entries are cleared.
- Same-cycle allocation and wb to discarded entries are dropped.
- A same-cycle valid commit is honoured before the flush.
- Committed entries and an in-flight drain are unaffected.
REQ-027 No output SHALL depend combinationally on mem_ready_i.

Reset
REQ-028 Asserting reset_n_i low at any time, including mid-drain, SHALL immediately set:
- head, commit_pt, tail and count to 0; sb_wb_vector_o = 0;
- FSM = D_IDLE; mem_v_o = 0;
- alloc_ready_o = 1, sb_empty_o = 1, commit_ready_o = 0, alloc_sb_num_o = 0, sb_commit_pt_o = 0.
REQ-029 Stored address and data SHALL need no reset. mem_addr_o and mem_data_o are don't-care while mem_v_o = 0.

Verification (SB_ENTRY=8)
REQ-030 Basic drain: alloc 3 (nums 0,1,2), wb all, commit 3, mem_ready_i=1 -> 3 consecutive mem_v_o cycles in order 0,1,2, then sb_empty_o=1 and sb_wb_vector_o=0.
REQ-031 Full and wrap: alloc 8 -> alloc_ready_o=0 at count 8; drain 2 and alloc 2 -> alloc_sb_num_o gives 0 and 1 again, tail wraps.
REQ-032 Backpressure: mem_ready_i held low 5 cycles -> mem_v_o, mem_addr_o and mem_data_o stable all 5 cycles, head unchanged.
REQ-033 Flush: alloc 5, commit 2, flush_i together with alloc_v_i -> tail=2, count=2, sb_wb_vector_o bits 2-4 = 0, the allocation dropped.
REQ-034 Commit gating: commit_v_i at entry 0 without wb -> commit_pt stays 0; after wb, commit_ready_o=1 and commit_pt becomes 1.
REQ-035 Reset mid-drain: reset_n_i low while mem_v_o=1 -> mem_v_o=0 asynchronously and all reset values of REQ-028 hold.
